// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: processes WIDTH-bit operands CHUNK bits per clock,
// LSB slice first, linking slices through a registered carry.
module chunked_adder_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned CntW = (NCH > 1) ? $clog2(NCH) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_adder_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              last;
  logic [CHUNK:0]    slice_sum;
  logic              msb_cin;

  assign accept = start && (state_q != StRun);
  assign last   = (cnt_q == CntW'(NCH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

  // Operands shift right each RUN cycle so the current slice is always at the bottom.
  assign slice_sum = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
  assign msb_cin   = opa_q[CHUNK-1] ^ opb_q[CHUNK-1] ^ slice_sum[CHUNK-1];

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (accept) begin
      opa_d   = a;
      opb_d   = sub ? ~b : b;
      carry_d = sub ? 1'b1 : c_in;
      cnt_d   = '0;
      s_d     = '0;
      c_out_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == StRun) begin
      opa_d   = opa_q >> CHUNK;
      opb_d   = opb_q >> CHUNK;
      carry_d = slice_sum[CHUNK];
      // Hold on the final slice so the counter never wraps within an operation.
      cnt_d   = last ? cnt_q : cnt_q + CntW'(1);
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cnt_q == CntW'(i)) begin
          s_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        end
      end
      if (last) begin
        c_out_d = slice_sum[CHUNK];
        ovf_d   = msb_cin ^ slice_sum[CHUNK];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Bench for chunked_adder_seq: directed vectors on (16,4) plus random sweeps on
// (16,1), (16,16) and (8,2) against a whole-word arithmetic model.
module tb_chunked_adder_seq;

  localparam int NI = 4;

  function automatic int w_of(int g);
    case (g)
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int c_of(int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 16;
      default: return 2;
    endcase
  endfunction

  logic            clk;
  logic            resetn;
  logic [NI-1:0]   start_v, ci_v, sub_v;
  logic [NI-1:0]   busy_v, done_v, co_v, ov_v;
  logic [15:0]     a_v [NI];
  logic [15:0]     b_v [NI];
  logic [15:0]     s_v [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = w_of(g);
    localparam int C = c_of(g);
    logic [W-1:0] s_l;
    chunked_adder_seq #(
      .WIDTH(W),
      .CHUNK(C)
    ) u_dut (
      .clk   (clk),
      .resetn(resetn),
      .start (start_v[g]),
      .a     (a_v[g][W-1:0]),
      .b     (b_v[g][W-1:0]),
      .c_in  (ci_v[g]),
      .sub   (sub_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .s     (s_l),
      .c_out (co_v[g]),
      .ovf   (ov_v[g])
    );
    assign s_v[g] = 16'(s_l);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on instance g; returns results sampled in the done cycle.
  task automatic run_op(input int g, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, output logic [15:0] so,
                        output logic co, output logic ov, output int lat,
                        output int bcy);
    start_v[g] = 1'b1;
    a_v[g]     = av;
    b_v[g]     = bv;
    ci_v[g]    = ci;
    sub_v[g]   = sb;
    step();
    start_v[g] = 1'b0;
    // Scramble inputs: captured operands must not follow them.
    a_v[g]     = ~av;
    b_v[g]     = ~bv;
    ci_v[g]    = ~ci;
    sub_v[g]   = ~sb;
    lat = 0;
    bcy = 0;
    while (!done_v[g] && lat < 64) begin
      if (busy_v[g]) bcy++;
      step();
      lat++;
    end
    so = s_v[g];
    co = co_v[g];
    ov = ov_v[g];
    check("busy_in_done", busy_v[g], 1'b0);
  endtask

  function automatic void model(input int w, input int unsigned av, input int unsigned bv,
                                input bit ci, input bit sb, output int unsigned so,
                                output bit co, output bit ov);
    int unsigned m, hm, bb, c, sum, low;
    m   = (32'd1 << w) - 1;
    hm  = m >> 1;
    bb  = sb ? (~bv & m) : (bv & m);
    c   = sb ? 1 : {31'd0, ci};
    sum = (av & m) + bb + c;
    low = (av & hm) + (bb & hm) + c;
    so  = sum & m;
    co  = ((sum >> w) & 1) != 0;
    ov  = (((low >> (w - 1)) & 1) != 0) ^ co;
  endfunction

  logic [15:0] so;
  logic        co, ov;
  int          lat, bcy, nd;

  initial begin
    resetn  = 1'b0;
    start_v = '0;
    ci_v    = '0;
    sub_v   = '0;
    for (int g = 0; g < NI; g++) begin
      a_v[g] = '0;
      b_v[g] = '0;
    end
    step();
    step();
    for (int g = 0; g < NI; g++) begin
      check("rst_busy", busy_v[g], 1'b0);
      check("rst_done", done_v[g], 1'b0);
      check("rst_s", s_v[g], 16'h0);
      check("rst_cout", co_v[g], 1'b0);
      check("rst_ovf", ov_v[g], 1'b0);
    end
    resetn = 1'b1;
    step();

    // Basic add, latency and single-cycle done
    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, so, co, ov, lat, bcy);
    check("t1_s", so, 16'h5555);
    check("t1_cout", co, 1'b0);
    check("t1_ovf", ov, 1'b0);
    check("t1_lat", lat, 4);
    check("t1_busy_cycles", bcy, 4);
    step();
    check("t1_done_pulse", done_v[0], 1'b0);
    check("t1_hold_s", s_v[0], 16'h5555);

    // Full ripple
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, so, co, ov, lat, bcy);
    check("t2a_s", so, 16'h0000);
    check("t2a_cout", co, 1'b1);
    check("t2a_ovf", ov, 1'b0);
    step();
    run_op(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, so, co, ov, lat, bcy);
    check("t2b_s", so, 16'h0001);
    check("t2b_cout", co, 1'b1);
    step();

    // Overflow and subtraction
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, so, co, ov, lat, bcy);
    check("t3a_s", so, 16'h8000);
    check("t3a_cout", co, 1'b0);
    check("t3a_ovf", ov, 1'b1);
    step();
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, so, co, ov, lat, bcy);
    check("t3b_s", so, 16'h7FFF);
    check("t3b_cout", co, 1'b1);
    check("t3b_ovf", ov, 1'b1);
    step();
    run_op(0, 16'h0003, 16'h0005, 1'b1, 1'b1, so, co, ov, lat, bcy);
    check("t3c_s", so, 16'hFFFE);
    check("t3c_cout", co, 1'b0);
    check("t3c_ovf", ov, 1'b0);
    step();

    // Held start ignored during RUN, then accepted in the done cycle
    start_v[0] = 1'b1;
    a_v[0]     = 16'h0001;
    b_v[0]     = 16'h0002;
    ci_v[0]    = 1'b0;
    sub_v[0]   = 1'b0;
    step();
    a_v[0] = 16'h1111;
    b_v[0] = 16'h1111;
    for (int k = 0; k < 4; k++) begin
      check("t4_busy_a", busy_v[0], 1'b1);
      step();
    end
    check("t4_done_a", done_v[0], 1'b1);
    check("t4_s_a", s_v[0], 16'h0003);
    step();
    start_v[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t4_busy_b", busy_v[0], 1'b1);
      check("t4_nodone_b", done_v[0], 1'b0);
      step();
    end
    check("t4_done_b", done_v[0], 1'b1);
    check("t4_s_b", s_v[0], 16'h2222);
    step();

    // Reset during the second RUN cycle aborts the operation
    start_v[0] = 1'b1;
    a_v[0]     = 16'h1234;
    b_v[0]     = 16'h0001;
    step();
    start_v[0] = 1'b0;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("t5_busy", busy_v[0], 1'b0);
    check("t5_done", done_v[0], 1'b0);
    check("t5_s", s_v[0], 16'h0);
    check("t5_cout", co_v[0], 1'b0);
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (done_v[0]) nd++;
      step();
    end
    check("t5_no_done", nd, 0);
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, so, co, ov, lat, bcy);
    check("t5_s_after", so, 16'h0100);
    check("t5_lat_after", lat, 4);
    step();

    // Random sweep on the other geometries
    for (int g = 1; g < NI; g++) begin
      int w, nch;
      w   = w_of(g);
      nch = w / c_of(g);
      for (int it = 0; it < 200; it++) begin
        int unsigned ea, eb, es;
        bit eci, esb, eco, eov;
        ea  = $urandom & ((32'd1 << w) - 1);
        eb  = $urandom & ((32'd1 << w) - 1);
        eci = 1'($urandom_range(0, 1));
        esb = 1'($urandom_range(0, 1));
        model(w, ea, eb, eci, esb, es, eco, eov);
        run_op(g, 16'(ea), 16'(eb), eci, esb, so, co, ov, lat, bcy);
        check($sformatf("sw%0d_s", g), so, es);
        check($sformatf("sw%0d_cout", g), co, eco);
        check($sformatf("sw%0d_ovf", g), ov, eov);
        check($sformatf("sw%0d_lat", g), lat, nch);
        if (it % 2 == 0) step();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
